// File: rtl/omsp_atomicity_monitor_nested_pkg.sv
// rtl/omsp_atomicity_monitor_nested_pkg.sv - shared cause codes and default bounds for the atomicity monitor
package omsp_atomicity_monitor_nested_pkg;

  localparam int DEF_ATOM_BOUND   = 10;
  localparam int DEF_ENTRY_PERIOD = 8;
  localparam int DEF_NEST_DEPTH   = 2;

  typedef enum logic [2:0] {
    ATOM_VIOL_NONE        = 3'd0,
    ATOM_VIOL_NEST        = 3'd1,
    ATOM_VIOL_BOUND       = 3'd2,
    ATOM_VIOL_SM_IN_CLIX  = 3'd3,
    ATOM_VIOL_SM_IN_ENTRY = 3'd4
  } atom_viol_e;

endpackage

// File: rtl/omsp_atom_budget_stack.sv
// rtl/omsp_atom_budget_stack.sv - stack of per-level clix budget counters that count down together
module omsp_atom_budget_stack #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 5,
  parameter int LVL_W = 2
) (
  input  logic             mclk,
  input  logic             puc_rst,
  input  logic             push,
  input  logic [CNT_W-1:0] push_val,
  input  logic             pop_all,
  output logic [LVL_W-1:0] depth,
  output logic [CNT_W-1:0] top,
  output logic [LVL_W-1:0] post_depth,
  output logic [CNT_W-1:0] post_top
);

  logic [CNT_W-1:0] cnt     [DEPTH];
  logic [CNT_W-1:0] cnt_nxt [DEPTH];
  logic [LVL_W-1:0] depth_nxt;

  // Inner budgets never exceed outer ones, so the levels surviving this cycle
  // (counter above 1) always form a bottom prefix of the stack.
  always_comb begin
    top        = '0;
    post_depth = '0;
    post_top   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (LVL_W'(i) < depth) begin
        top = cnt[i];
        if (!pop_all && cnt[i] > CNT_W'(1)) begin
          post_depth = LVL_W'(i + 1);
          post_top   = cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  // Survivors decrement, the new level lands just above them, everything else clears.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nxt[i] = '0;
      if (LVL_W'(i) < post_depth)
        cnt_nxt[i] = cnt[i] - CNT_W'(1);
      else if (push && LVL_W'(i) == post_depth)
        cnt_nxt[i] = push_val;
    end
    depth_nxt = post_depth + LVL_W'(push);
  end

  // Counter and depth registers.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      depth <= '0;
      for (int i = 0; i < DEPTH; i++) cnt[i] <= '0;
    end else begin
      depth <= depth_nxt;
      for (int i = 0; i < DEPTH; i++) cnt[i] <= cnt_nxt[i];
    end
  end

endmodule

// File: rtl/omsp_atomicity_monitor_nested.sv
// rtl/omsp_atomicity_monitor_nested.sv - nested clix / SM-entry atomicity monitor producing effective GIE
module omsp_atomicity_monitor_nested
  import omsp_atomicity_monitor_nested_pkg::*;
#(
  parameter int  ATOM_BOUND   = DEF_ATOM_BOUND,
  parameter int  ENTRY_PERIOD = DEF_ENTRY_PERIOD,
  parameter int  NEST_DEPTH   = DEF_NEST_DEPTH,
  localparam int CNT_W        = $clog2(ATOM_BOUND) + 1,
  localparam int ENT_W        = $clog2(ENTRY_PERIOD) + 1,
  localparam int LVL_W        = $clog2(NEST_DEPTH + 1)
) (
  input  logic             mclk,
  input  logic             puc_rst,
  input  logic             inst_clix,
  input  logic [CNT_W-1:0] clix_len,
  input  logic             enter_sm,
  input  logic             priv_mode,
  input  logic             sm_executing,
  input  logic             restrict_gie,
  input  logic             r2_gie,
  input  logic             handling_irq,
  output logic             gie,
  output logic             atom_violation,
  output logic [2:0]       viol_cause,
  output logic [LVL_W-1:0] nest_level,
  output logic [CNT_W-1:0] budget_left
);

  logic [LVL_W-1:0] depth, post_depth;
  logic [CNT_W-1:0] top, post_top, push_val;
  logic             push, pop_all;
  logic [ENT_W-1:0] entry_cnt, entry_nxt;
  logic             entry_active, entry_end, entry_load;
  logic             close_all, clix_nest, clix_bound, clix_ok;
  logic             sm_in_clix, sm_in_entry, pop_to_empty, rel;
  atom_viol_e       cause;

  omsp_atom_budget_stack #(
    .DEPTH (NEST_DEPTH),
    .CNT_W (CNT_W),
    .LVL_W (LVL_W)
  ) u_stack (
    .mclk       (mclk),
    .puc_rst    (puc_rst),
    .push       (push),
    .push_val   (push_val),
    .pop_all    (pop_all),
    .depth      (depth),
    .top        (top),
    .post_depth (post_depth),
    .post_top   (post_top)
  );

  // Event legality, push sizing and entry-period control.
  always_comb begin
    close_all    = restrict_gie & priv_mode & enter_sm;
    entry_active = (entry_cnt != '0);
    // Popping levels still count as open, so a full stack always refuses a clix.
    clix_nest    = inst_clix & (depth == LVL_W'(NEST_DEPTH));
    clix_bound   = inst_clix & (clix_len > CNT_W'(ATOM_BOUND));
    clix_ok      = inst_clix & ~clix_nest & ~clix_bound;
    sm_in_clix   = enter_sm & (depth != '0) & ~close_all;
    sm_in_entry  = enter_sm & entry_active & ~(restrict_gie & priv_mode);
    pop_all      = r2_gie | handling_irq | close_all;
    // Clip against the enclosing level's next-cycle value so the inner level ends with it.
    push_val     = (post_depth != '0 && post_top < clix_len) ? post_top : clix_len;
    push         = clix_ok & (push_val != '0);
    entry_end    = entry_active & ((entry_cnt == ENT_W'(1)) | inst_clix | handling_irq
                                   | close_all | sm_in_entry);
    entry_load   = enter_sm & ~close_all & ~sm_in_clix & ~sm_in_entry;
    entry_nxt    = entry_cnt;
    if (entry_load)        entry_nxt = ENT_W'(ENTRY_PERIOD);
    else if (entry_end)    entry_nxt = '0;
    else if (entry_active) entry_nxt = entry_cnt - ENT_W'(1);
  end

  // Effective GIE: a section closing this cycle already re-enables interrupts.
  always_comb begin
    pop_to_empty = (depth != '0) & (post_depth == '0);
    rel          = pop_to_empty | entry_end;
    gie          = (r2_gie | rel) & ~inst_clix & ~enter_sm
                   & ((depth == '0) | pop_to_empty)
                   & (~entry_active | entry_end)
                   & ~(restrict_gie & priv_mode & sm_executing);
  end

  // Violation priority encoder; silent while reset is held.
  always_comb begin
    cause = ATOM_VIOL_NONE;
    if (clix_nest)        cause = ATOM_VIOL_NEST;
    else if (clix_bound)  cause = ATOM_VIOL_BOUND;
    else if (sm_in_clix)  cause = ATOM_VIOL_SM_IN_CLIX;
    else if (sm_in_entry) cause = ATOM_VIOL_SM_IN_ENTRY;
    atom_violation = (cause != ATOM_VIOL_NONE) & ~puc_rst;
    viol_cause     = atom_violation ? cause : ATOM_VIOL_NONE;
    nest_level     = depth;
    budget_left    = top;
  end

  // Entry-period counter.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) entry_cnt <= '0;
    else         entry_cnt <= entry_nxt;
  end

endmodule

// File: tb/tb_omsp_atomicity_monitor_nested.sv
// tb/tb_omsp_atomicity_monitor_nested.sv - directed self-checking bench for the atomicity monitor
module tb_omsp_atomicity_monitor_nested;

  logic       mclk = 1'b0;
  logic       puc_rst = 1'b1;
  logic       inst_clix = 1'b0;
  logic [4:0] clix_len = 5'd0;
  logic       enter_sm = 1'b0;
  logic       priv_mode = 1'b0;
  logic       sm_executing = 1'b0;
  logic       restrict_gie = 1'b0;
  logic       r2_gie = 1'b0;
  logic       handling_irq = 1'b0;
  logic       gie;
  logic       atom_violation;
  logic [2:0] viol_cause;
  logic [1:0] nest_level;
  logic [4:0] budget_left;

  int checks = 0;
  int failures = 0;

  omsp_atomicity_monitor_nested dut (
    .mclk           (mclk),
    .puc_rst        (puc_rst),
    .inst_clix      (inst_clix),
    .clix_len       (clix_len),
    .enter_sm       (enter_sm),
    .priv_mode      (priv_mode),
    .sm_executing   (sm_executing),
    .restrict_gie   (restrict_gie),
    .r2_gie         (r2_gie),
    .handling_irq   (handling_irq),
    .gie            (gie),
    .atom_violation (atom_violation),
    .viol_cause     (viol_cause),
    .nest_level     (nest_level),
    .budget_left    (budget_left)
  );

  always #5 mclk = ~mclk;

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic idle();
    inst_clix = 0; clix_len = 0; enter_sm = 0; priv_mode = 0; sm_executing = 0;
    restrict_gie = 0; r2_gie = 0; handling_irq = 0;
  endtask

  task automatic test_reset();
    r2_gie = 1; #1;
    checks++; if (gie !== 1'b1) begin failures++; $display("FAIL rst_gie_hi got=%0d exp=1", gie); end
    checks++; if (nest_level !== 2'd0) begin failures++; $display("FAIL rst_nest got=%0d exp=0", nest_level); end
    checks++; if (budget_left !== 5'd0) begin failures++; $display("FAIL rst_budget got=%0d exp=0", budget_left); end
    checks++; if (atom_violation !== 1'b0 || viol_cause !== 3'd0) begin failures++; $display("FAIL rst_viol got=%0d/%0d exp=0/0", atom_violation, viol_cause); end
    r2_gie = 0; #1;
    checks++; if (gie !== 1'b0) begin failures++; $display("FAIL rst_gie_lo got=%0d exp=0", gie); end
    step(); puc_rst = 0; step();
  endtask

  task automatic test_clix_single();
    inst_clix = 1; clix_len = 5; #1;
    checks++; if (gie !== 1'b0 || atom_violation !== 1'b0) begin failures++; $display("FAIL clix5_c0 gie=%0d viol=%0d exp 0/0", gie, atom_violation); end
    step(); idle(); #1;
    checks++; if (nest_level !== 2'd1) begin failures++; $display("FAIL clix5_nest got=%0d exp=1", nest_level); end
    for (int k = 1; k <= 4; k++) begin
      checks++; if (gie !== 1'b0 || budget_left !== 5'(6 - k)) begin failures++; $display("FAIL clix5_c%0d gie=%0d budget=%0d exp 0/%0d", k, gie, budget_left, 6 - k); end
      step();
    end
    checks++; if (gie !== 1'b1 || budget_left !== 5'd1) begin failures++; $display("FAIL clix5_release gie=%0d budget=%0d exp 1/1", gie, budget_left); end
    step();
    checks++; if (nest_level !== 2'd0 || gie !== 1'b0 || budget_left !== 5'd0) begin failures++; $display("FAIL clix5_after nest=%0d gie=%0d budget=%0d exp 0/0/0", nest_level, gie, budget_left); end
  endtask

  task automatic test_nested();
    inst_clix = 1; clix_len = 6; step(); idle(); step();
    inst_clix = 1; clix_len = 9; #1;
    checks++; if (atom_violation !== 1'b0) begin failures++; $display("FAIL nest_inner_viol got=%0d exp=0", atom_violation); end
    step(); idle(); #1;
    checks++; if (nest_level !== 2'd2 || budget_left !== 5'd4) begin failures++; $display("FAIL nest_clip nest=%0d budget=%0d exp 2/4", nest_level, budget_left); end
    step(); step(); step();
    checks++; if (gie !== 1'b1 || nest_level !== 2'd2 || budget_left !== 5'd1) begin failures++; $display("FAIL nest_release gie=%0d nest=%0d budget=%0d exp 1/2/1", gie, nest_level, budget_left); end
    step();
    checks++; if (nest_level !== 2'd0) begin failures++; $display("FAIL nest_pop_together got=%0d exp=0", nest_level); end
  endtask

  task automatic test_violations();
    inst_clix = 1; clix_len = 6; step(); idle(); step();
    inst_clix = 1; clix_len = 9; step(); idle();
    inst_clix = 1; clix_len = 3; #1;
    checks++; if (atom_violation !== 1'b1 || viol_cause !== 3'd1) begin failures++; $display("FAIL viol_nest got=%0d/%0d exp=1/1", atom_violation, viol_cause); end
    step(); idle(); #1;
    checks++; if (nest_level !== 2'd2 || budget_left !== 5'd3) begin failures++; $display("FAIL viol_nest_nopush nest=%0d budget=%0d exp 2/3", nest_level, budget_left); end
    r2_gie = 1; #1;
    checks++; if (gie !== 1'b1) begin failures++; $display("FAIL r2_popall_gie got=%0d exp=1", gie); end
    step(); idle(); #1;
    checks++; if (nest_level !== 2'd0) begin failures++; $display("FAIL r2_popall_nest got=%0d exp=0", nest_level); end
    inst_clix = 1; clix_len = 11; #1;
    checks++; if (atom_violation !== 1'b1 || viol_cause !== 3'd2) begin failures++; $display("FAIL viol_bound got=%0d/%0d exp=1/2", atom_violation, viol_cause); end
    step(); idle(); #1;
    checks++; if (nest_level !== 2'd0) begin failures++; $display("FAIL viol_bound_nopush got=%0d exp=0", nest_level); end
    inst_clix = 1; clix_len = 4; step(); idle();
    enter_sm = 1; #1;
    checks++; if (atom_violation !== 1'b1 || viol_cause !== 3'd3) begin failures++; $display("FAIL viol_sm_in_clix got=%0d/%0d exp=1/3", atom_violation, viol_cause); end
    step(); idle(); r2_gie = 1; step(); idle(); step();
  endtask

  task automatic test_entry();
    enter_sm = 1; #1;
    checks++; if (gie !== 1'b0 || atom_violation !== 1'b0) begin failures++; $display("FAIL entry_c0 gie=%0d viol=%0d exp 0/0", gie, atom_violation); end
    step(); idle();
    for (int k = 1; k <= 7; k++) begin
      checks++; if (gie !== 1'b0) begin failures++; $display("FAIL entry_c%0d gie=%0d exp=0", k, gie); end
      step();
    end
    checks++; if (gie !== 1'b1) begin failures++; $display("FAIL entry_release gie=%0d exp=1", gie); end
    step();
    r2_gie = 1; #1;
    checks++; if (gie !== 1'b1) begin failures++; $display("FAIL entry_over gie=%0d exp=1", gie); end
    step(); idle();
    enter_sm = 1; step(); idle(); step(); step();
    enter_sm = 1; #1;
    checks++; if (atom_violation !== 1'b1 || viol_cause !== 3'd4) begin failures++; $display("FAIL viol_sm_in_entry got=%0d/%0d exp=1/4", atom_violation, viol_cause); end
    step(); idle(); r2_gie = 1; #1;
    checks++; if (gie !== 1'b1) begin failures++; $display("FAIL entry_ended_by_viol gie=%0d exp=1", gie); end
    step(); idle();
  endtask

  task automatic test_restrict();
    enter_sm = 1; step(); idle(); step(); step();
    enter_sm = 1; restrict_gie = 1; priv_mode = 1; #1;
    checks++; if (atom_violation !== 1'b0 || viol_cause !== 3'd0) begin failures++; $display("FAIL restrict_noviol got=%0d/%0d exp=0/0", atom_violation, viol_cause); end
    step(); enter_sm = 0; r2_gie = 1; #1;
    checks++; if (gie !== 1'b1) begin failures++; $display("FAIL restrict_no_period gie=%0d exp=1", gie); end
    sm_executing = 1; #1;
    checks++; if (gie !== 1'b0) begin failures++; $display("FAIL restrict_sm_gate gie=%0d exp=0", gie); end
    step(); idle(); step();
  endtask

  task automatic test_abort();
    inst_clix = 1; clix_len = 7; step(); idle(); step();
    r2_gie = 1; #1;
    checks++; if (gie !== 1'b1) begin failures++; $display("FAIL r2_abort_gie got=%0d exp=1", gie); end
    step(); idle(); #1;
    checks++; if (nest_level !== 2'd0 || budget_left !== 5'd0) begin failures++; $display("FAIL r2_abort_empty nest=%0d budget=%0d exp 0/0", nest_level, budget_left); end
    enter_sm = 1; step(); idle(); step();
    handling_irq = 1; #1;
    checks++; if (gie !== 1'b1) begin failures++; $display("FAIL irq_abort_gie got=%0d exp=1", gie); end
    step(); idle(); r2_gie = 1; #1;
    checks++; if (gie !== 1'b1) begin failures++; $display("FAIL irq_abort_over gie=%0d exp=1", gie); end
    step(); idle();
  endtask

  task automatic test_back_to_back();
    inst_clix = 1; clix_len = 2; step(); idle(); step();
    inst_clix = 1; clix_len = 3; #1;
    checks++; if (atom_violation !== 1'b0 || gie !== 1'b0) begin failures++; $display("FAIL b2b_c2 viol=%0d gie=%0d exp 0/0", atom_violation, gie); end
    step(); idle(); #1;
    checks++; if (nest_level !== 2'd1 || budget_left !== 5'd3) begin failures++; $display("FAIL b2b_reopen nest=%0d budget=%0d exp 1/3", nest_level, budget_left); end
    r2_gie = 1; step(); idle(); step();
  endtask

  task automatic test_reset_mid();
    inst_clix = 1; clix_len = 7; step(); idle(); step(); step(); step();
    checks++; if (budget_left !== 5'd4) begin failures++; $display("FAIL rstmid_pre budget=%0d exp=4", budget_left); end
    puc_rst = 1; inst_clix = 1; clix_len = 11; #1;
    checks++; if (nest_level !== 2'd0 || budget_left !== 5'd0) begin failures++; $display("FAIL rstmid_clear nest=%0d budget=%0d exp 0/0", nest_level, budget_left); end
    checks++; if (atom_violation !== 1'b0 || viol_cause !== 3'd0) begin failures++; $display("FAIL rstmid_viol got=%0d/%0d exp=0/0", atom_violation, viol_cause); end
    idle(); step(); puc_rst = 0; step();
  endtask

  initial begin
    test_reset();
    test_clix_single();
    test_nested();
    test_violations();
    test_entry();
    test_restrict();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
